// File: rtl/spi_xfer_sequencer.sv
// APB master that runs multi-byte SPI transfers through the APB SPI peripheral
// on behalf of two round-robin arbitrated requesters.
module spi_xfer_sequencer #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned POLL_MAX = 1023
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [1:0]         req_i,
  input  logic [5:0]         dev_i,
  input  logic [2*LEN_W-1:0] len_i,
  input  logic [7:0]         tx_data_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic [7:0]         rx_data_o,
  output logic               rx_valid_o,
  input  logic               rx_ready_i,
  output logic [1:0]         gnt_o,
  output logic [1:0]         done_o,
  output logic               err_o,
  output logic [7:0]         PADDR,
  output logic               PWRITE,
  output logic               PSEL,
  output logic               PENABLE,
  output logic [7:0]         PWDATA,
  input  logic [7:0]         PRDATA,
  input  logic               PREADY
);

  localparam int unsigned PCNT_W = $clog2(POLL_MAX + 1);

  localparam logic [7:0] ADDR_SPSR = 8'h08;
  localparam logic [7:0] ADDR_SPDR = 8'h10;
  localparam logic [7:0] ADDR_SSEL = 8'h20;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_SEL, S_GETTX, S_WRDAT, S_POLL, S_RDDAT, S_PUSH, S_DESEL, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ptr, w_ptr_nxt;
  logic              r_gidx, w_gidx_nxt;
  logic [2:0]        r_dev, w_dev_nxt;
  logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
  logic [PCNT_W-1:0] r_poll, w_poll_nxt;
  logic              r_err, w_err_nxt;
  logic [7:0]        r_tx_byte, w_tx_byte_nxt;

  logic              r_tx_ready, w_tx_ready_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic [7:0]        r_rx_data, w_rx_data_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic [1:0]        r_done, w_done_nxt;
  logic              r_err_o, w_err_o_nxt;
  logic              r_psel, w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic              r_pwrite, w_pwrite_nxt;
  logic [7:0]        r_paddr, w_paddr_nxt;
  logic [7:0]        r_pwdata, w_pwdata_nxt;

  logic              w_apb_state;
  logic              w_apb_done;
  logic              w_sel;
  logic [7:0]        w_acc_addr;
  logic              w_acc_write;
  logic [7:0]        w_acc_wdata;
  logic [PCNT_W-1:0] w_poll_inc;

  assign w_apb_done = r_psel & r_penable & PREADY;
  assign w_sel      = req_i[r_ptr] ? r_ptr : ~r_ptr;
  assign w_poll_inc = (r_poll == PCNT_W'(POLL_MAX)) ? r_poll : r_poll + PCNT_W'(1);

  // APB access issued by each bus-owning state
  always_comb begin
    w_apb_state = 1'b1;
    w_acc_addr  = ADDR_SSEL;
    w_acc_write = 1'b1;
    w_acc_wdata = 8'h00;
    case (r_state)
      S_SEL:   w_acc_wdata = 8'({1'b1, r_dev});
      S_WRDAT: begin
        w_acc_addr  = ADDR_SPDR;
        w_acc_wdata = r_tx_byte;
      end
      S_POLL:  begin
        w_acc_addr  = ADDR_SPSR;
        w_acc_write = 1'b0;
      end
      S_RDDAT: begin
        w_acc_addr  = ADDR_SPDR;
        w_acc_write = 1'b0;
      end
      S_DESEL: w_acc_wdata = 8'h00;
      default: w_apb_state = 1'b0;
    endcase
  end

  // next-state and registered-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_gidx_nxt     = r_gidx;
    w_dev_nxt      = r_dev;
    w_cnt_nxt      = r_cnt;
    w_poll_nxt     = r_poll;
    w_err_nxt      = r_err;
    w_tx_byte_nxt  = r_tx_byte;
    w_tx_ready_nxt = r_tx_ready;
    w_rx_valid_nxt = r_rx_valid;
    w_rx_data_nxt  = r_rx_data;
    w_gnt_nxt      = r_gnt;
    w_done_nxt     = 2'b00;
    w_err_o_nxt    = 1'b0;
    w_psel_nxt     = r_psel;
    w_penable_nxt  = r_penable;
    w_pwrite_nxt   = r_pwrite;
    w_paddr_nxt    = r_paddr;
    w_pwdata_nxt   = r_pwdata;

    // idle cycle -> SETUP -> ACCESS until PREADY; bus drops after every access
    if (w_apb_state) begin
      if (!r_psel) begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b0;
        w_paddr_nxt   = w_acc_addr;
        w_pwrite_nxt  = w_acc_write;
        w_pwdata_nxt  = w_acc_wdata;
      end else if (!r_penable) begin
        w_penable_nxt = 1'b1;
      end else if (PREADY) begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    end

    case (r_state)
      S_IDLE: if (|req_i) w_state_nxt = S_ARB;
      S_ARB: begin
        if (|req_i) begin
          w_gidx_nxt  = w_sel;
          w_gnt_nxt   = w_sel ? 2'b10 : 2'b01;
          w_dev_nxt   = w_sel ? dev_i[5:3] : dev_i[2:0];
          w_cnt_nxt   = w_sel ? len_i[2*LEN_W-1:LEN_W] : len_i[LEN_W-1:0];
          w_ptr_nxt   = ~w_sel;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_SEL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEL: begin
        if (w_apb_done) begin
          if (r_cnt == '0) begin
            w_state_nxt = S_DESEL;
          end else begin
            w_tx_ready_nxt = 1'b1;
            w_state_nxt    = S_GETTX;
          end
        end
      end
      S_GETTX: begin
        if (tx_valid_i) begin
          w_tx_byte_nxt  = tx_data_i;
          w_tx_ready_nxt = 1'b0;
          w_state_nxt    = S_WRDAT;
        end
      end
      S_WRDAT: begin
        if (w_apb_done) begin
          w_poll_nxt  = '0;
          w_state_nxt = S_POLL;
        end
      end
      S_POLL: begin
        if (w_apb_done) begin
          if (!PRDATA[0]) begin
            w_state_nxt = S_RDDAT;
          end else begin
            w_poll_nxt = w_poll_inc;
            if (w_poll_inc == PCNT_W'(POLL_MAX)) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_DESEL;
            end
          end
        end
      end
      S_RDDAT: begin
        if (w_apb_done) begin
          w_rx_data_nxt  = PRDATA;
          w_rx_valid_nxt = 1'b1;
          w_state_nxt    = S_PUSH;
        end
      end
      S_PUSH: begin
        if (rx_ready_i) begin
          w_rx_valid_nxt = 1'b0;
          w_cnt_nxt      = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            w_state_nxt = S_DESEL;
          end else begin
            w_tx_ready_nxt = 1'b1;
            w_state_nxt    = S_GETTX;
          end
        end
      end
      S_DESEL: begin
        if (w_apb_done) begin
          w_done_nxt  = r_gidx ? 2'b10 : 2'b01;
          w_err_o_nxt = r_err;
          w_gnt_nxt   = 2'b00;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_err_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_gidx     <= 1'b0;
      r_dev      <= '0;
      r_cnt      <= '0;
      r_poll     <= '0;
      r_err      <= 1'b0;
      r_tx_byte  <= '0;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err_o    <= 1'b0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gidx     <= w_gidx_nxt;
      r_dev      <= w_dev_nxt;
      r_cnt      <= w_cnt_nxt;
      r_poll     <= w_poll_nxt;
      r_err      <= w_err_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_gnt      <= w_gnt_nxt;
      r_done     <= w_done_nxt;
      r_err_o    <= w_err_o_nxt;
      r_psel     <= w_psel_nxt;
      r_penable  <= w_penable_nxt;
      r_pwrite   <= w_pwrite_nxt;
      r_paddr    <= w_paddr_nxt;
      r_pwdata   <= w_pwdata_nxt;
    end
  end

  assign tx_ready_o = r_tx_ready;
  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
  assign gnt_o      = r_gnt;
  assign done_o     = r_done;
  assign err_o      = r_err_o;
  assign PSEL       = r_psel;
  assign PENABLE    = r_penable;
  assign PWRITE     = r_pwrite;
  assign PADDR      = r_paddr;
  assign PWDATA     = r_pwdata;

endmodule
